mem_port_arbiter: RTL and testbench

- Shares the single memory port of the MMU between two requesters: instruction fetch and data load/store.
- Requesters see a simple req/ack handshake. The memory side sees one latched address, write-enable and write-data, and the block follows the MMU's request/busy protocol.
- Sits between the core pipeline and the MMU, and removes the need for two independent MMU ports.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, MMU and status signals of the fetch/data memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BUS_WIDTH     = 8
) ();
  logic                     fetchReq;
  logic [ADDRESS_WIDTH-1:0] fetchAddr;
  logic                     fetchAck;
  logic [BUS_WIDTH-1:0]     fetchData;

  logic                     dataReq;
  logic [ADDRESS_WIDTH-1:0] dataAddr;
  logic                     dataWe;
  logic [BUS_WIDTH-1:0]     dataWdata;
  logic                     dataAck;
  logic [BUS_WIDTH-1:0]     dataRdata;

  logic                     memReq;
  logic [ADDRESS_WIDTH-1:0] memAddr;
  logic                     memWe;
  logic [BUS_WIDTH-1:0]     memWdata;
  logic [BUS_WIDTH-1:0]     memRdata;
  logic                     memBusy;

  logic                     grantData;
  logic                     error;

  modport master (
    input  fetchReq, fetchAddr,
    output fetchAck, fetchData,
    input  dataReq, dataAddr, dataWe, dataWdata,
    output dataAck, dataRdata,
    output memReq, memAddr, memWe, memWdata,
    input  memRdata, memBusy,
    output grantData, error
  );

  modport slave (
    output fetchReq, fetchAddr,
    input  fetchAck, fetchData,
    output dataReq, dataAddr, dataWe, dataWdata,
    input  dataAck, dataRdata,
    input  memReq, memAddr, memWe, memWdata,
    output memRdata, memBusy,
    input  grantData, error
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter onto the single MMU request/busy port
// Optional watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int BUS_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  logic                     grant_data_q, grant_data_d;
  logic                     mem_req_q, mem_req_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                     mem_we_q, mem_we_d;
  logic [BUS_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic                     fetch_ack_q, fetch_ack_d;
  logic                     data_ack_q, data_ack_d;
  logic [BUS_WIDTH-1:0]     fetch_data_q, fetch_data_d;
  logic [BUS_WIDTH-1:0]     data_rdata_q, data_rdata_d;
  logic                     pick_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             error_q, error_d;
`endif

  // Data wins when it is alone, or on a tie when fetch owned the port last.
  assign pick_data = bus.dataReq && (!bus.fetchReq || !last_grant_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_data_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      fetch_ack_q  <= 1'b0;
      data_ack_q   <= 1'b0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_data_q <= grant_data_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      fetch_ack_q  <= fetch_ack_d;
      data_ack_q   <= data_ack_d;
      fetch_data_q <= fetch_data_d;
      data_rdata_q <= data_rdata_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_data_d = grant_data_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    fetch_ack_d  = 1'b0;
    data_ack_d   = 1'b0;
    fetch_data_d = fetch_data_q;
    data_rdata_d = data_rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
    error_d      = error_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (!bus.memBusy && (bus.fetchReq || bus.dataReq)) begin
          mem_req_d    = 1'b1;
          grant_data_d = pick_data;
          last_grant_d = pick_data;
          state_d      = ST_ISSUE;
          if (pick_data) begin
            mem_addr_d  = bus.dataAddr;
            mem_we_d    = bus.dataWe;
            mem_wdata_d = bus.dataWdata;
          end else begin
            mem_addr_d  = bus.fetchAddr;
            mem_we_d    = 1'b0;
          end
`ifdef MEM_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      ST_ISSUE: begin
        if (bus.memBusy) begin
          mem_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.memBusy) begin
          if (!mem_we_q) begin
            if (grant_data_q) data_rdata_d = bus.memRdata;
            else              fetch_data_d = bus.memRdata;
          end
          mem_we_d = 1'b0;
          if (grant_data_q) data_ack_d  = 1'b1;
          else              fetch_ack_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef MEM_TIMEOUT_EN
    // A normal completion on the same edge takes precedence over the watchdog.
    if ((state_q == ST_ISSUE || state_q == ST_WAIT) && state_d != ST_DONE) begin
      cnt_d = cnt_inc;
      if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        error_d   = 1'b1;
        state_d   = ST_DONE;
        if (grant_data_q) begin
          data_ack_d = 1'b1;
          if (!mem_we_q) data_rdata_d = '1;
        end else begin
          fetch_ack_d  = 1'b1;
          fetch_data_d = '1;
        end
      end
    end
`endif
  end

  assign bus.memReq    = mem_req_q;
  assign bus.memAddr   = mem_addr_q;
  assign bus.memWe     = mem_we_q;
  assign bus.memWdata  = mem_wdata_q;
  assign bus.fetchAck  = fetch_ack_q;
  assign bus.fetchData = fetch_data_q;
  assign bus.dataAck   = data_ack_q;
  assign bus.dataRdata = data_rdata_q;
  assign bus.grantData = grant_data_q;
`ifdef MEM_TIMEOUT_EN
  assign bus.error     = error_q;
`else
  assign bus.error     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus ();

  mem_port_arbiter #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_memreq(input string tag);
    int n = 0;
    while (bus.memReq !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_memreq"}, bus.memReq, 1);
  endtask

  // MMU model: busy seen on the edge after memReq, held for `hold` edges, then read data returned.
  task automatic mmu_serve(input string tag, input logic [31:0] exp_addr, input logic exp_we,
                           input logic [7:0] exp_wdata, input logic exp_grant,
                           input logic [7:0] rdata, input int hold, input bit scramble);
    wait_memreq(tag);
    chk({tag, "_addr"}, bus.memAddr, exp_addr);
    chk({tag, "_we"}, bus.memWe, exp_we);
    chk({tag, "_grant"}, bus.grantData, exp_grant);
    if (exp_we) chk({tag, "_wdata"}, bus.memWdata, exp_wdata);
    if (scramble) begin
      bus.dataAddr  = 32'hDEAD_0000;
      bus.dataWdata = 8'hC3;
      bus.dataWe    = 1'b0;
      bus.dataReq   = 1'b0;
      bus.fetchAddr = 32'h0000_BEEF;
    end
    bus.memBusy = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_req_off"}, bus.memReq, 0);
      chk({tag, "_we_hold"}, bus.memWe, exp_we);
      chk({tag, "_addr_hold"}, bus.memAddr, exp_addr);
      if (exp_we) chk({tag, "_wdata_hold"}, bus.memWdata, exp_wdata);
    end
    bus.memRdata = rdata;
    bus.memBusy  = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        g;
    logic [31:0] ea;
    logic [7:0]  rd;

    reset         = 1'b0;
    bus.fetchReq  = 1'b0;
    bus.fetchAddr = '0;
    bus.dataReq   = 1'b0;
    bus.dataAddr  = '0;
    bus.dataWe    = 1'b0;
    bus.dataWdata = '0;
    bus.memRdata  = '0;
    bus.memBusy   = 1'b0;
    repeat (3) tick();
    chk("rst_memreq", bus.memReq, 0);
    chk("rst_memaddr", bus.memAddr, 0);
    chk("rst_memwe", bus.memWe, 0);
    chk("rst_fetchack", bus.fetchAck, 0);
    chk("rst_dataack", bus.dataAck, 0);
    chk("rst_grant", bus.grantData, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_fetchdata", bus.fetchData, 0);
    chk("rst_datardata", bus.dataRdata, 0);
    reset = 1'b1;
    tick();

    // Tie arbitration with both requests held throughout.
    bus.fetchAddr = 32'h40;
    bus.dataAddr  = 32'h80;
    bus.dataWe    = 1'b0;
    bus.fetchReq  = 1'b1;
    bus.dataReq   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g  = k[0];
      ea = g ? 32'h80 : 32'h40;
      rd = 8'(8'h11 * (k + 1));
      mmu_serve($sformatf("tie%0d", k), ea, 1'b0, 8'h00, g, rd, 2, 1'b0);
      chk($sformatf("tie%0d_fack", k), bus.fetchAck, {31'd0, ~g});
      chk($sformatf("tie%0d_dack", k), bus.dataAck, {31'd0, g});
      if (g) chk($sformatf("tie%0d_drdata", k), bus.dataRdata, rd);
      else   chk($sformatf("tie%0d_fdata", k), bus.fetchData, rd);
      if (k == 3) begin
        bus.fetchReq = 1'b0;
        bus.dataReq  = 1'b0;
      end
      tick();
      chk($sformatf("tie%0d_pulse", k), {bus.fetchAck, bus.dataAck}, 0);
    end

    // Single fetch read.
    bus.fetchAddr = 32'h10;
    bus.fetchReq  = 1'b1;
    mmu_serve("fread", 32'h10, 1'b0, 8'h00, 1'b0, 8'hA5, 2, 1'b0);
    chk("fread_fack", bus.fetchAck, 1);
    chk("fread_dack", bus.dataAck, 0);
    chk("fread_fdata", bus.fetchData, 8'hA5);
    chk("fread_drdata", bus.dataRdata, 8'h44);
    bus.fetchReq = 1'b0;
    tick();
    chk("fread_pulse", {bus.fetchAck, bus.dataAck}, 0);

    // Data write; inputs scrambled and request dropped after grant.
    bus.dataAddr  = 32'h120;
    bus.dataWe    = 1'b1;
    bus.dataWdata = 8'h3C;
    bus.dataReq   = 1'b1;
    mmu_serve("dwrite", 32'h120, 1'b1, 8'h3C, 1'b1, 8'h99, 2, 1'b1);
    chk("dwrite_dack", bus.dataAck, 1);
    chk("dwrite_we_clr", bus.memWe, 0);
    chk("dwrite_drdata", bus.dataRdata, 8'h44);
    chk("dwrite_fdata", bus.fetchData, 8'hA5);
    tick();
    chk("dwrite_pulse", bus.dataAck, 0);

    // MMU busy while idle blocks the grant.
    bus.memBusy   = 1'b1;
    bus.fetchAddr = 32'h10;
    bus.fetchReq  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bidle_hold", bus.memReq, 0);
    end
    bus.memBusy = 1'b0;
    chk("bidle_noedge", bus.memReq, 0);
    tick();
    chk("bidle_rise", bus.memReq, 1);
    mmu_serve("bidle", 32'h10, 1'b0, 8'h00, 1'b0, 8'h5A, 1, 1'b0);
    chk("bidle_fack", bus.fetchAck, 1);
    chk("bidle_fdata", bus.fetchData, 8'h5A);
    bus.fetchReq = 1'b0;
    tick();

    // Asynchronous reset during WAIT.
    bus.dataAddr  = 32'h200;
    bus.dataWe    = 1'b1;
    bus.dataWdata = 8'h77;
    bus.dataReq   = 1'b1;
    wait_memreq("rstop");
    bus.memBusy = 1'b1;
    tick();
    chk("rstop_pre_we", bus.memWe, 1);
    chk("rstop_pre_grant", bus.grantData, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rstop_memreq", bus.memReq, 0);
    chk("rstop_memwe", bus.memWe, 0);
    chk("rstop_acks", {bus.fetchAck, bus.dataAck}, 0);
    chk("rstop_grant", bus.grantData, 0);
    chk("rstop_addr", bus.memAddr, 0);
    bus.memBusy = 1'b0;
    bus.dataReq = 1'b0;
    bus.dataWe  = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bus.fetchAddr = 32'h44;
    bus.dataAddr  = 32'h88;
    bus.fetchReq  = 1'b1;
    bus.dataReq   = 1'b1;
    mmu_serve("rsttie", 32'h44, 1'b0, 8'h00, 1'b0, 8'h66, 2, 1'b0);
    chk("rsttie_fack", bus.fetchAck, 1);
    chk("rsttie_dack", bus.dataAck, 0);
    bus.fetchReq = 1'b0;
    bus.dataReq  = 1'b0;
    tick();

`ifdef MEM_TIMEOUT_EN
    // Data read where the MMU never answers.
    bus.dataAddr = 32'h300;
    bus.dataWe   = 1'b0;
    bus.dataReq  = 1'b1;
    wait_memreq("tmo");
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("tmo_wait%0d", i), bus.dataAck, 0);
    end
    tick();
    chk("tmo_dack", bus.dataAck, 1);
    chk("tmo_drdata", bus.dataRdata, 8'hFF);
    chk("tmo_error", bus.error, 1);
    chk("tmo_memreq", bus.memReq, 0);
    bus.dataReq = 1'b0;
    tick();
    chk("tmo_sticky", bus.error, 1);
    chk("tmo_pulse", bus.dataAck, 0);
    bus.fetchAddr = 32'h10;
    bus.fetchReq  = 1'b1;
    mmu_serve("after_tmo", 32'h10, 1'b0, 8'h00, 1'b0, 8'hC0, 2, 1'b0);
    chk("after_tmo_fack", bus.fetchAck, 1);
    chk("after_tmo_fdata", bus.fetchData, 8'hC0);
    chk("after_tmo_error", bus.error, 1);
    bus.fetchReq = 1'b0;
    tick();
`else
    chk("error_tied", bus.error, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
